// File: rtl/clk_div_checker.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_checker
// Description : Measures the period and high time of a divided-clock pulse
//               train sampled on the fast clock, declares lock after a run of
//               good periods and flags every bad period or missing edge.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_checker #(
    parameter int PERIOD   = 4,
    parameter int HIGH     = 1,
    parameter int LOCK_CNT = 3,
    parameter int CW       = 8,
    parameter int ECW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pulse_in,
    output logic           locked,
    output logic           err,
    output logic [ECW-1:0] err_cnt,
    output logic [CW-1:0]  period_meas,
    output logic [CW-1:0]  high_meas
);

    // good_cnt only ever has to hold 0..LOCK_CNT-1
    localparam int GCW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [CW-1:0]  c_PERIOD   = CW'(PERIOD);
    localparam logic [CW-1:0]  c_HIGH     = CW'(HIGH);
    localparam logic [CW-1:0]  c_TIMEOUT  = CW'(2 * PERIOD);
    localparam logic [CW-1:0]  c_CNT_MAX  = {CW{1'b1}};
    localparam logic [ECW-1:0] c_ERR_MAX  = {ECW{1'b1}};
    localparam logic [GCW-1:0] c_GOOD_LST = GCW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GCW-1:0]  r_good_cnt;
    logic [GCW-1:0]  w_good_cnt_nxt;
    logic            r_pulse_d;
    logic [CW-1:0]   r_per_cnt;
    logic [CW-1:0]   r_hi_cnt;
    logic            r_err;
    logic [ECW-1:0]  r_err_cnt;
    logic [CW-1:0]   r_period_meas;
    logic [CW-1:0]   r_high_meas;

    logic            w_rise;
    logic            w_good;
    logic            w_timeout;
    logic            w_err_nxt;
    logic            w_meas_ld;

    assign w_rise    = pulse_in & ~r_pulse_d;
    // per_cnt/hi_cnt still hold the period that just ended during the rise cycle
    assign w_good    = (r_per_cnt == c_PERIOD) && (r_hi_cnt == c_HIGH);
    assign w_timeout = (r_per_cnt == c_TIMEOUT) && !w_rise;

    // Edge detector and period / high-time measurement counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse_d <= 1'b0;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            r_pulse_d <= pulse_in;
            if (w_rise) begin
                r_per_cnt <= CW'(1);
                r_hi_cnt  <= CW'(1);
            end else begin
                if (r_per_cnt != c_CNT_MAX) begin
                    r_per_cnt <= r_per_cnt + 1'b1;
                end
                if (pulse_in && (r_hi_cnt != c_CNT_MAX)) begin
                    r_hi_cnt <= r_hi_cnt + 1'b1;
                end
            end
        end
    end

    // Lock state register and good-period run counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_SEARCH;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
        end
    end

    // Next-state logic: judge each completed period at its closing rise
    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_err_nxt      = 1'b0;
        w_meas_ld      = 1'b0;
        case (r_state)
            S_SEARCH: begin
                // first rise only opens a period; nothing to judge yet
                if (w_rise) begin
                    w_state_nxt    = S_TRACK;
                    w_good_cnt_nxt = '0;
                end
            end
            S_TRACK: begin
                if (w_rise) begin
                    w_meas_ld = 1'b1;
                    if (w_good) begin
                        if (r_good_cnt == c_GOOD_LST) begin
                            w_state_nxt    = S_LOCKED;
                            w_good_cnt_nxt = '0;
                        end else begin
                            w_good_cnt_nxt = r_good_cnt + 1'b1;
                        end
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_good_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = S_SEARCH;
                    w_good_cnt_nxt = '0;
                end
            end
            S_LOCKED: begin
                if (w_rise) begin
                    w_meas_ld = 1'b1;
                    if (!w_good) begin
                        w_err_nxt      = 1'b1;
                        w_state_nxt    = S_TRACK;
                        w_good_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = S_SEARCH;
                    w_good_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = S_SEARCH;
                w_good_cnt_nxt = '0;
            end
        endcase
    end

    // Fault strobe, saturating fault counter and captured measurements
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err         <= 1'b0;
            r_err_cnt     <= '0;
            r_period_meas <= '0;
            r_high_meas   <= '0;
        end else begin
            r_err <= w_err_nxt;
            if (w_err_nxt && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_meas_ld) begin
                r_period_meas <= r_per_cnt;
                r_high_meas   <= r_hi_cnt;
            end
        end
    end

    assign locked      = (r_state == S_LOCKED);
    assign err         = r_err;
    assign err_cnt     = r_err_cnt;
    assign period_meas = r_period_meas;
    assign high_meas   = r_high_meas;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_checker
// Description : Scoreboard bench for clk_div_checker. Stimulus pushes the
//               hand-computed response expected at each fault strobe; a
//               monitor pops and compares whenever err is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_checker;

    logic       clk = 1'b0;
    logic       rst, pulse_in;
    logic       locked, err;
    logic [7:0] err_cnt, period_meas, high_meas;

    logic       rst2, pulse2;
    logic       locked2, err2;
    logic [1:0] err_cnt2;
    logic [7:0] period_meas2, high_meas2;

    always #5 clk = ~clk;

    clk_div_checker u_dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt),
        .period_meas (period_meas),
        .high_meas   (high_meas)
    );

    clk_div_checker #(.ECW(2)) u_dut_sat (
        .clk         (clk),
        .rst         (rst2),
        .pulse_in    (pulse2),
        .locked      (locked2),
        .err         (err2),
        .err_cnt     (err_cnt2),
        .period_meas (period_meas2),
        .high_meas   (high_meas2)
    );

    typedef struct {
        int cnt;
        int per;
        int hi;
        int lk;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2, t2;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   err2_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one fast-clock cycle of stimulus on each DUT
    task automatic tick(input logic v);
        pulse_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic tick2(input logic v);
        pulse2 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int h, input int l);
        repeat (h) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    task automatic period2(input int h, input int l);
        repeat (h) tick2(1'b1);
        repeat (l) tick2(1'b0);
    endtask

    // three ideal periods, then the lock-producing rise; lock must appear exactly then
    task automatic lock_seq(input string tag);
        repeat (3) period(1, 3);
        chk({tag, "_locked_before"}, int'(locked), 0);
        tick(1'b1);
        chk({tag, "_locked_after"}, int'(locked), 1);
        repeat (3) tick(1'b0);
    endtask

    // Scoreboard monitors: compare every observed fault strobe with the queue
    always @(negedge clk) begin
        if (err === 1'b1) begin
            if (q1.size() == 0) begin
                chk("unexpected_err", 1, 0);
            end else begin
                m1 = q1.pop_front();
                chk("sb_err_cnt", int'(err_cnt), m1.cnt);
                chk("sb_period_meas", int'(period_meas), m1.per);
                chk("sb_high_meas", int'(high_meas), m1.hi);
                chk("sb_locked", int'(locked), m1.lk);
            end
        end
        if (err2 === 1'b1) begin
            err2_seen++;
            if (q2.size() == 0) begin
                chk("unexpected_err_sat", 1, 0);
            end else begin
                m2 = q2.pop_front();
                chk("sat_err_cnt", int'(err_cnt2), m2.cnt);
                chk("sat_period_meas", int'(period_meas2), m2.per);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pulse_in = 1'b0;
        rst2 = 1'b1; pulse2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_period_meas", int'(period_meas), 0);
        chk("rst_high_meas", int'(high_meas), 0);

        // nominal: rises at cycles 0,4,8,12; measurements valid from cycle 5
        period(1, 3);
        tick(1'b1);
        chk("nom_period_meas", int'(period_meas), 4);
        chk("nom_high_meas", int'(high_meas), 1);
        repeat (3) tick(1'b0);
        period(1, 3);
        chk("nom_locked_c12", int'(locked), 0);
        tick(1'b1);
        chk("nom_locked_c13", int'(locked), 1);
        repeat (3) tick(1'b0);
        chk("nom_err_cnt", int'(err_cnt), 0);

        // bad duty while locked: 2 high, 2 low
        q1.push_back('{1, 4, 2, 0});
        period(2, 2);
        lock_seq("duty");

        // bad period: 1 high, 4 low
        q1.push_back('{2, 5, 1, 0});
        period(1, 4);
        lock_seq("per");
        chk("per_period_meas", int'(period_meas), 4);

        // stuck low: last rise at R, timeout sampled at R+8, visible at R+9
        q1.push_back('{3, 4, 1, 0});
        repeat (4) tick(1'b0);
        chk("stuck_locked_r8", int'(locked), 1);
        tick(1'b0);
        chk("stuck_locked_r9", int'(locked), 0);
        repeat (5) tick(1'b0);
        chk("stuck_err_quiet", int'(err), 0);
        lock_seq("stuck");

        // reset while locked, coinciding with a rise
        pulse_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_locked", int'(locked), 0);
        chk("mrst_err", int'(err), 0);
        chk("mrst_err_cnt", int'(err_cnt), 0);
        chk("mrst_period_meas", int'(period_meas), 0);
        chk("mrst_high_meas", int'(high_meas), 0);
        lock_seq("mrst");

        // first fault after reset counts from 1 again
        q1.push_back('{1, 5, 1, 0});
        period(1, 4);
        period(1, 3);
        chk("mrst_relock_lost", int'(locked), 0);

        // park the first DUT so it raises no timeout while the second runs
        rst = 1'b1;
        tick(1'b0);

        // saturation with a 2-bit error counter: five bad 5-cycle periods
        rst2 = 1'b0;
        period2(1, 4);
        for (int k = 1; k <= 5; k++) begin
            t2.cnt = (k > 3) ? 3 : k;
            t2.per = 5;
            t2.hi  = 1;
            t2.lk  = 0;
            q2.push_back(t2);
            period2(1, 4);
        end
        rst2 = 1'b1;
        repeat (3) tick2(1'b0);

        chk("sat_err_pulses", err2_seen, 5);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
